// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv
// Pipelined multi-channel N-input AND/NAND reduction with valid/ready flow control
// and a saturating count of completed output handshakes.
module gf180mcu_fd_sc_mcu9t5v0__nandn_pipe #(
  parameter int N_IN     = 3,
  parameter int CHANNELS = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CHANNELS*N_IN-1:0] A,
  input  logic                     MODE,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [CHANNELS-1:0]      ZN,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  input  logic                     CNT_CLR,
  output logic [15:0]              TXN_CNT
);

  localparam int L = $clog2(N_IN);
  localparam int P = 1 << L;

  logic [CHANNELS*P-1:0] padded;
  logic [L-1:0]          v;
  logic [L-1:0]          v_src;
  logic [L-1:0]          adv;
  logic [L-1:0]          load;

  // Each channel is widened to a power of two; unused leaves read as 1 so the AND is unaffected.
  always_comb begin
    padded = '1;
    for (int c = 0; c < CHANNELS; c++) begin
      padded[c*P +: N_IN] = A[c*N_IN +: N_IN];
    end
  end

  // Readiness ripples backwards from the output so a full pipeline can still advance every cycle.
  always_comb begin
    adv       = '0;
    load      = '0;
    v_src     = '0;
    adv[L-1]  = v[L-1] & OUT_READY;
    load[L-1] = ~v[L-1] | adv[L-1];
    for (int k = L - 2; k >= 0; k--) begin
      adv[k]  = v[k] & load[k+1];
      load[k] = ~v[k] | adv[k];
    end
    v_src[0] = IN_VALID;
    for (int k = 1; k < L; k++) begin
      v_src[k] = v[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v <= '0;
    end else begin
      v <= (v & ~load) | (v_src & load);
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int WI = P >> k;
    localparam int WO = P >> (k + 1);

    logic [CHANNELS*WI-1:0] src;
    logic                   src_mode;
    logic [CHANNELS*WO-1:0] reduced;
    logic [CHANNELS*WO-1:0] data_q;

    if (k == 0) begin : g_src0
      assign src      = padded;
      assign src_mode = MODE;
    end else begin : g_srcn
      assign src      = g_stage[k-1].data_q;
      assign src_mode = g_stage[k-1].g_mid.mode_q;
    end

    // The final level folds in the NAND inversion so MODE costs no extra cycle.
    always_comb begin
      reduced = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < WO; i++) begin
          reduced[c*WO + i] = src[c*WI + 2*i] & src[c*WI + 2*i + 1];
        end
      end
      if (k == L - 1 && !src_mode) begin
        reduced = ~reduced;
      end
    end

    if (k == L - 1) begin : g_last
      always_ff @(posedge CLK) begin
        if (RST) begin
          data_q <= '0;
        end else if (load[k]) begin
          data_q <= reduced;
        end
      end
    end else begin : g_mid
      logic mode_q;
      always_ff @(posedge CLK) begin
        if (load[k]) begin
          data_q <= reduced;
          mode_q <= src_mode;
        end
      end
    end
  end

  assign IN_READY  = load[0];
  assign OUT_VALID = v[L-1];
  assign ZN        = g_stage[L-1].data_q;

  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      TXN_CNT <= '0;
    end else if (OUT_VALID && OUT_READY && TXN_CNT != 16'hFFFF) begin
      TXN_CNT <= TXN_CNT + 16'd1;
    end
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.md
GF180MCU_FD_SC_MCU9T5V0__NANDN_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__nandn_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 3: inputs per channel, legal range 2..16.
REQ-002 SHALL have parameter CHANNELS, default 2: independent reduction channels, legal range 1..8.
REQ-003 SHALL define derived constant L = clog2(N_IN), the pipeline depth in cycles (N_IN=2 gives 1, N_IN=3 gives 2, N_IN=16 gives 4).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port A, input, CHANNELS*N_IN bits: channel c operands in A[c*N_IN +: N_IN].
REQ-007 SHALL have port MODE, input, 1 bit: per-transaction function select; 0 = NAND, 1 = AND.
REQ-008 SHALL have port IN_VALID, input, 1 bit: A and MODE are valid.
REQ-009 SHALL have port IN_READY, output, 1 bit: the block accepts the input this cycle.
REQ-010 SHALL have port ZN, output, CHANNELS bits: per-channel result.
REQ-011 SHALL have port OUT_VALID, output, 1 bit: ZN is valid.
REQ-012 SHALL have port OUT_READY, input, 1 bit: the consumer accepts ZN.
REQ-013 SHALL have port CNT_CLR, input, 1 bit: synchronous clear of TXN_CNT.
REQ-014 SHALL have port TXN_CNT, output, 16 bits: count of completed output handshakes.

Function
REQ-015 SHALL accept an input transaction when IN_VALID and IN_READY are both 1 on a rising edge.
REQ-016 SHALL complete an output transaction when OUT_VALID and OUT_READY are both 1 on a rising edge.
REQ-017 SHALL compute each channel's result as the AND of its N_IN bits, inverted when MODE=0; MODE is captured with the data and travels with it.
REQ-018 SHALL build each channel as a balanced tree of 2-input ANDs with L levels, registering after every level; when N_IN is not a power of two, missing leaves are padded with 1.
REQ-019 SHALL apply the MODE inversion in the last stage, so it adds no extra cycle.
REQ-020 SHALL give every stage k (0..L-1) its own valid bit V[k].
REQ-021 SHALL load stage k when V[k]=0 or stage k is advancing. Stage k advances when V[k]=1 and either stage k+1 loads or, for the last stage, OUT_READY=1.
REQ-022 SHALL drive IN_READY = !V[0] | stage-0-advancing, combinationally; bubbles collapse.
REQ-023 SHALL drive OUT_VALID = V[L-1] and ZN from the last-stage register.
REQ-024 SHALL keep ZN and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 SHALL have latency L cycles from input accept to OUT_VALID when no stall is present, with throughput 1 transaction/cycle.
REQ-026 SHALL never drop, duplicate or reorder transactions, and SHALL deliver them in acceptance order.
REQ-027 SHALL increment TXN_CNT on each output handshake and saturate it at 0xFFFF (no wrap).
REQ-028 SHALL give CNT_CLR priority: when CNT_CLR and an output handshake occur in the same cycle, TXN_CNT becomes 0.
REQ-029 SHALL let a stage accept new data in the same cycle its contents move downstream, with no cycle lost.

Reset
REQ-030 SHALL, while RST=1 on a rising edge, clear all V[k], ZN and TXN_CNT to 0; IN_READY then reads 1.
REQ-031 SHALL discard all in-flight transactions on a reset asserted mid-operation, with no output handshake for them.
REQ-032 SHALL give RST priority over all other inputs, including a same-cycle IN_VALID or CNT_CLR.
REQ-033 SHALL keep datapath registers without reset; their content is don't-care while the matching V[k]=0.

Verification
REQ-034 SHALL test basic function (N_IN=3, CHANNELS=2): A=6'b111_011, MODE=0, OUT_READY=1 -> ZN=2'b01, OUT_VALID high exactly 2 cycles after accept.
REQ-035 SHALL test MODE: same A with MODE=1 -> ZN=2'b10; then back-to-back MODE 0/1/0 -> results 01, 10, 01 on consecutive cycles.
REQ-036 SHALL test backpressure: a stream of 5 transactions with OUT_READY=0 for 4 cycles -> IN_READY drops after 2 are held, ZN stays stable, all 5 then emerge in order and TXN_CNT=5.
REQ-037 SHALL test reset mid-stream: RST pulsed with 2 transactions in flight -> OUT_VALID=0 the next cycle, IN_READY=1, TXN_CNT=0, and no stale output appears afterwards.
REQ-038 SHALL test the counter: preload via 65535 handshakes, then 1 more -> TXN_CNT=0xFFFF; CNT_CLR together with a handshake -> 0.
REQ-039 SHALL test parameter corners: N_IN=2 gives latency 1; N_IN=5 with A=5'b11111 and MODE=0 gives ZN=0, confirming the pad-with-1 rule.
